cam_capture: RTL and testbench

CAM_CAPTURE -- requirements
Module: cam_capture

---
 rtl/cam_pkg.sv | 28 ++
 rtl/cam_capture_if.sv | 19 +
 rtl/sync_fifo.sv | 66 ++++++
 rtl/cam_capture.sv | 250 +++++++++++++++++++++++++
 tb/tb_cam_capture.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cam_pkg.sv
// cam_pkg -- shared types and constants for the camera capture block.
//   cam_state_e : capture FSM states
//   cam_entry_t : output buffer entry {sof, eol, pixel}. Its pixel field is
//                 sized for the default bus (8-bit beats, 2 beats per pixel).
//                 cam_capture declares the same layout at its parameterised width.
//   CAM_*       : default resolution and bus geometry
package cam_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DROP    = 2'd3
    } cam_state_e;

    localparam int CAM_H_ACTIVE      = 640;
    localparam int CAM_V_ACTIVE      = 480;
    localparam int CAM_DATA_W        = 8;
    localparam int CAM_BYTES_PER_PIX = 2;
    localparam int CAM_PIX_W         = CAM_DATA_W * CAM_BYTES_PER_PIX;

    typedef struct packed {
        logic                 sof;
        logic                 eol;
        logic [CAM_PIX_W-1:0] pixel;
    } cam_entry_t;

endpackage

// File: rtl/cam_capture_if.sv
// cam_capture_if -- pixel output stream (valid/ready).
//   m_data  : pixel, first bus beat in the MSBs
//   m_sof   : first pixel of the frame
//   m_eol   : last pixel of a line
//   m_valid : word available
//   m_ready : consumer accepts the word
// The master modport is the producer side (cam_capture); the slave is the consumer.
interface cam_capture_if #(
    parameter int PIX_W = 16
) ();
    logic [PIX_W-1:0] m_data;
    logic             m_sof;
    logic             m_eol;
    logic             m_valid;
    logic             m_ready;

    modport master (output m_data, output m_sof, output m_eol, output m_valid, input m_ready);
    modport slave  (input m_data, input m_sof, input m_eol, input m_valid, output m_ready);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo -- single-clock first-word-fall-through FIFO.
//   clk, rst_n : clock, synchronous active-low reset (empties the FIFO)
//   wr_en_i    : write request; ignored when full unless a read happens
//                in the same cycle
//   wr_data_i  : write data
//   rd_en_i    : pop the head word (ignored when empty)
//   rd_data_o  : head word, valid whenever empty_o=0, zero when empty
//   full_o     : DEPTH words held
//   empty_o    : no words held
module sync_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_wr_s;
    logic             do_rd_s;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign do_rd_s   = rd_en_i & ~empty_o;
    // A full FIFO still accepts a write when the head is popped in the same cycle.
    assign do_wr_s   = wr_en_i & (~full_o | do_rd_s);
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // Storage array; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (do_wr_s) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_rd_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_wr_s, do_rd_s})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/cam_capture.sv
// cam_capture -- parallel camera (DVP) frame capture into a pixel stream.
//   clk, rst_n            : system clock (>= 4x plk), synchronous active-low reset
//   plk, D, vsync, hsync  : camera pins, asynchronous, oversampled on clk
//   start / continuous    : capture request / free-running mode (sampled on start)
//   stop                  : end capture at the next frame boundary
//   m_if                  : pixel output stream (master side)
//   busy                  : FSM not idle
//   frame_done/frame_err  : one-cycle pulses at frame end; err = short frame or overflow
//   overflow              : sticky, cleared by an accepted start
//   frame_cnt             : completed frames, wrapping
module cam_capture
    import cam_pkg::*;
#(
    parameter int DATA_W        = CAM_DATA_W,
    parameter int BYTES_PER_PIX = CAM_BYTES_PER_PIX,
    parameter int H_ACTIVE      = CAM_H_ACTIVE,
    parameter int V_ACTIVE      = CAM_V_ACTIVE,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              plk,
    input  logic [DATA_W-1:0] D,
    input  logic              vsync,
    input  logic              hsync,
    input  logic              start,
    input  logic              continuous,
    input  logic              stop,
    cam_capture_if.master     m_if,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_err,
    output logic              overflow,
    output logic [15:0]       frame_cnt
);
    localparam int PIX_W  = DATA_W * BYTES_PER_PIX;
    localparam int COL_W  = $clog2(H_ACTIVE + 1);
    localparam int LINE_W = $clog2(V_ACTIVE + 1);
    localparam logic [1:0]        LAST_BEAT = 2'(BYTES_PER_PIX - 1);
    localparam logic [COL_W-1:0]  COL_END   = COL_W'(H_ACTIVE);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(H_ACTIVE - 1);
    localparam logic [LINE_W-1:0] LINE_END  = LINE_W'(V_ACTIVE);

    // Same layout as cam_entry_t, at this instance's pixel width.
    typedef struct packed {
        logic             sof;
        logic             eol;
        logic [PIX_W-1:0] pixel;
    } entry_t;

    cam_state_e        state_q, state_d;
    logic              plk_m_q, plk_s_q, plk_p_q;
    logic              vs_m_q, vs_s_q, vs_p_q;
    logic              hs_m_q, hs_s_q, hs_p_q;
    logic [DATA_W-1:0] d_m_q, d_s_q;
    logic [COL_W-1:0]  col_q;
    logic [LINE_W-1:0] line_q, full_lines_q;
    logic [1:0]        beat_q;
    logic              line_has_beat_q;
    logic [PIX_W-1:0]  pix_q;
    logic              wr_q;
    entry_t            wr_entry_q, fifo_head_s;
    logic              frame_done_q, frame_err_q, overflow_q, cont_q, stop_pend_q;
    logic [15:0]       frame_cnt_q;
    logic              plk_rise_s, vs_rise_s, vs_fall_s, hs_fall_s;
    logic              beat_ok_s, pix_done_s, keep_s;
    logic [PIX_W-1:0]  pix_next_s;
    logic              fifo_full_s, fifo_empty_s, fifo_rd_s, fifo_wr_s, drop_s;
    logic              frame_end_s, clr_cnt_s, start_ok_s;

    assign plk_rise_s = plk_s_q & ~plk_p_q;
    assign vs_rise_s  = vs_s_q & ~vs_p_q;
    assign vs_fall_s  = ~vs_s_q & vs_p_q;
    assign hs_fall_s  = ~hs_s_q & hs_p_q;
    assign beat_ok_s  = plk_rise_s & hs_s_q & (state_q == ST_CAPTURE);
    assign pix_done_s = beat_ok_s & (beat_q == LAST_BEAT);
    assign keep_s     = (col_q < COL_END) & (line_q < LINE_END);
    // First beat ends up in the MSBs after BYTES_PER_PIX shifts.
    assign pix_next_s = (pix_q << DATA_W) | PIX_W'(d_s_q);
    assign fifo_rd_s  = m_if.m_ready & ~fifo_empty_s;
    assign fifo_wr_s  = wr_q & (~fifo_full_s | fifo_rd_s);
    assign drop_s     = wr_q & fifo_full_s & ~fifo_rd_s;

    // Two-flop synchronizers plus one history flop for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {plk_m_q, plk_s_q, plk_p_q} <= 3'b000;
            {vs_m_q, vs_s_q, vs_p_q}    <= 3'b000;
            {hs_m_q, hs_s_q, hs_p_q}    <= 3'b000;
            d_m_q <= '0;
            d_s_q <= '0;
        end else begin
            {plk_m_q, plk_s_q, plk_p_q} <= {plk, plk_m_q, plk_s_q};
            {vs_m_q, vs_s_q, vs_p_q}    <= {vsync, vs_m_q, vs_s_q};
            {hs_m_q, hs_s_q, hs_p_q}    <= {hsync, hs_m_q, hs_s_q};
            d_m_q <= D;
            d_s_q <= d_m_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and frame-boundary strobes.
    always_comb begin
        state_d     = state_q;
        frame_end_s = 1'b0;
        clr_cnt_s   = 1'b0;
        start_ok_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_WAIT_VS;
                    start_ok_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_VS: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (vs_fall_s) begin
                    state_d   = ST_CAPTURE;
                    clr_cnt_s = 1'b1;
                end else begin
                    state_d = ST_WAIT_VS;
                end
            end
            ST_CAPTURE, ST_DROP: begin
                if (vs_rise_s) begin
                    frame_end_s = 1'b1;
                    // A stop arriving on the very frame-end cycle still counts.
                    state_d = (!cont_q || stop_pend_q || stop) ? ST_IDLE : ST_WAIT_VS;
                end else if (drop_s) begin
                    state_d = ST_DROP;
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Beat/column/line counters and the byte assembler.
    always_ff @(posedge clk) begin
        if (!rst_n || clr_cnt_s) begin
            col_q           <= '0;
            line_q          <= '0;
            full_lines_q    <= '0;
            beat_q          <= 2'd0;
            line_has_beat_q <= 1'b0;
            pix_q           <= '0;
        end else if (beat_ok_s) begin
            pix_q           <= pix_next_s;
            line_has_beat_q <= 1'b1;
            if (pix_done_s) begin
                beat_q <= 2'd0;
                // Column saturates: anything past H_ACTIVE is discarded anyway.
                col_q  <= (col_q < COL_END) ? col_q + COL_W'(1) : col_q;
            end else begin
                beat_q <= beat_q + 2'd1;
            end
        end else if (hs_fall_s && (state_q == ST_CAPTURE)) begin
            beat_q          <= 2'd0;
            col_q           <= '0;
            line_has_beat_q <= 1'b0;
            if (line_has_beat_q && (line_q < LINE_END)) begin
                line_q <= line_q + LINE_W'(1);
            end
            if ((col_q == COL_END) && (line_q < LINE_END)) begin
                full_lines_q <= full_lines_q + LINE_W'(1);
            end
        end
    end

    // Completed, in-window pixels are registered here and written one clk later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q       <= 1'b0;
            wr_entry_q <= '0;
        end else begin
            wr_q <= pix_done_s & keep_s;
            if (pix_done_s) begin
                wr_entry_q <= '{sof:   (line_q == '0) && (col_q == '0),
                                eol:   (col_q == COL_LAST),
                                pixel: pix_next_s};
            end
        end
    end

    // Frame status, mode and stop bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            frame_cnt_q  <= 16'd0;
            overflow_q   <= 1'b0;
            cont_q       <= 1'b0;
            stop_pend_q  <= 1'b0;
        end else begin
            frame_done_q <= frame_end_s;
            frame_err_q  <= frame_end_s &
                            ((state_q == ST_DROP) | drop_s | (full_lines_q < LINE_END));
            if (frame_end_s) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (start_ok_s) begin
                overflow_q <= 1'b0;
                cont_q     <= continuous;
            end else if (drop_s) begin
                overflow_q <= 1'b1;
            end
            if (state_d == ST_IDLE) begin
                stop_pend_q <= 1'b0;
            end else if (stop) begin
                stop_pend_q <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (fifo_wr_s),
        .wr_data_i (wr_entry_q),
        .rd_en_i   (fifo_rd_s),
        .rd_data_o (fifo_head_s),
        .full_o    (fifo_full_s),
        .empty_o   (fifo_empty_s)
    );

    assign m_if.m_valid = ~fifo_empty_s;
    assign m_if.m_data  = fifo_head_s.pixel;
    assign m_if.m_sof   = fifo_head_s.sof;
    assign m_if.m_eol   = fifo_head_s.eol;
    assign busy         = (state_q != ST_IDLE);
    assign frame_done   = frame_done_q;
    assign frame_err    = frame_err_q;
    assign overflow     = overflow_q;
    assign frame_cnt    = frame_cnt_q;
endmodule

// File: tb/tb_cam_capture.sv
// tb_cam_capture -- self-checking bench for cam_capture on a 4x2 frame,
// 8-bit bus, 2 beats per pixel, 4-entry output FIFO.
module tb_cam_capture;
    import cam_pkg::*;

    localparam int H_T = 4;
    localparam int V_T = 2;

    logic        clk = 1'b0;
    logic        rst_n, plk, vsync, hsync, start, continuous, stop;
    logic [7:0]  D;
    logic        busy, frame_done, frame_err, overflow;
    logic [15:0] frame_cnt;

    cam_capture_if #(.PIX_W(16)) m_if ();

    cam_capture #(
        .DATA_W(8), .BYTES_PER_PIX(2), .H_ACTIVE(H_T), .V_ACTIVE(V_T), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .plk(plk), .D(D), .vsync(vsync), .hsync(hsync),
        .start(start), .continuous(continuous), .stop(stop), .m_if(m_if),
        .busy(busy), .frame_done(frame_done), .frame_err(frame_err),
        .overflow(overflow), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    cam_entry_t exp_q[$];
    cam_entry_t got_q[$];
    int         got_rd = 0;
    int         fd_cnt = 0;
    int         fe_cnt = 0;
    int         exp_frames = 0;
    logic [7:0] fr_byte [4][12];
    int         fr_len [4];
    int         fr_nl;

    typedef struct {
        int len0; int len1; int nl; bit p1234; int exp_words; bit exp_err;
    } vec_t;
    vec_t tbl [6];

    // Passive monitor: accepted words and status pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (m_if.m_valid && m_if.m_ready) begin
            got_q.push_back('{sof: m_if.m_sof, eol: m_if.m_eol, pixel: m_if.m_data});
        end
        if (frame_done) fd_cnt++;
        if (frame_err)  fe_cnt++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic beat(input logic [7:0] b);
        D = b;
        wait_clk(1);
        plk = 1'b1;
        wait_clk(3);
        plk = 1'b0;
        wait_clk(2);
    endtask

    task automatic pulse_start(input logic cont);
        start = 1'b1; continuous = cont;
        wait_clk(1);
        start = 1'b0;
        wait_clk(2);
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        wait_clk(1);
        stop = 1'b0;
        wait_clk(2);
    endtask

    task automatic fill_frame(input int nl, input int l0, input int l1, input bit p1234);
        fr_nl = nl;
        for (int l = 0; l < 4; l++) begin
            fr_len[l] = (l == 0) ? l0 : l1;
            for (int i = 0; i < 12; i++) begin
                if (p1234) fr_byte[l][i] = (i % 2 == 0) ? 8'h12 : 8'h34;
                else       fr_byte[l][i] = 8'($urandom_range(0, 255));
            end
        end
    endtask

    // Camera side of one frame; starts and ends with vsync high.
    task automatic drive_frame(input bit stop_mid);
        vsync = 1'b0;
        wait_clk(8);
        for (int l = 0; l < fr_nl; l++) begin
            hsync = 1'b1;
            wait_clk(2);
            for (int i = 0; i < fr_len[l]; i++) beat(fr_byte[l][i]);
            hsync = 1'b0;
            wait_clk(6);
            if (stop_mid && l == 0) pulse_stop();
        end
        vsync = 1'b1;
        wait_clk(12);
    endtask

    // Reference: lines with beats are numbered in order; each carries len/2
    // whole pixels, of which the first H_T are kept on the first V_T lines.
    task automatic model_frame(output bit err);
        int li;
        int full;
        int npix;
        cam_entry_t e;
        li = 0; full = 0;
        for (int l = 0; l < fr_nl; l++) begin
            if (fr_len[l] > 0) begin
                if (li < V_T) begin
                    npix = fr_len[l] / 2;
                    for (int c = 0; c < npix && c < H_T; c++) begin
                        e.sof   = (li == 0) && (c == 0);
                        e.eol   = (c == H_T - 1);
                        e.pixel = {fr_byte[l][2*c], fr_byte[l][2*c+1]};
                        exp_q.push_back(e);
                    end
                    if (npix >= H_T) full++;
                end
                li++;
            end
        end
        err = (full < V_T);
    endtask

    task automatic check_words(input string nm);
        int n_got;
        n_got = got_q.size() - got_rd;
        chk({nm, "_count"}, 32'(n_got), 32'(exp_q.size()));
        for (int i = 0; i < n_got && i < exp_q.size(); i++) begin
            chk($sformatf("%s_w%0d", nm, i), 32'(got_q[got_rd + i]), 32'(exp_q[i]));
        end
        got_rd += n_got;
        exp_q.delete();
    endtask

    initial begin
        bit   err;
        int   fd0, fe0, nw;
        tbl[0] = '{8, 8, 2, 1'b1, 8, 1'b0};
        tbl[1] = '{3, 8, 2, 1'b0, 5, 1'b1};
        tbl[2] = '{8, 0, 1, 1'b0, 4, 1'b1};
        tbl[3] = '{10, 8, 2, 1'b0, 8, 1'b0};
        tbl[4] = '{8, 8, 3, 1'b0, 8, 1'b0};
        tbl[5] = '{7, 8, 2, 1'b0, 7, 1'b1};

        rst_n = 1'b0; plk = 1'b0; vsync = 1'b1; hsync = 1'b0; D = 8'h00;
        start = 1'b0; continuous = 1'b0; stop = 1'b0; m_if.m_ready = 1'b1;
        wait_clk(3);
        chk("rst_valid", 32'(m_if.m_valid), 32'd0);
        chk("rst_data", 32'(m_if.m_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_done_err", 32'({frame_done, frame_err}), 32'd0);
        rst_n = 1'b1;
        wait_clk(5);

        // Table-driven frame shapes.
        for (int r = 0; r < 6; r++) begin
            fill_frame(tbl[r].nl, tbl[r].len0, tbl[r].len1, tbl[r].p1234);
            fd0 = fd_cnt; fe0 = fe_cnt;
            pulse_start(1'b0);
            chk($sformatf("tbl%0d_busy_armed", r), 32'(busy), 32'd1);
            model_frame(err);
            drive_frame(1'b0);
            exp_frames++;
            nw = got_q.size() - got_rd;
            chk($sformatf("tbl%0d_nwords", r), 32'(nw), 32'(tbl[r].exp_words));
            if (r == 0 && nw > 0) chk("tbl0_first_pixel", 32'(got_q[got_rd].pixel), 32'h1234);
            check_words($sformatf("tbl%0d", r));
            chk($sformatf("tbl%0d_done", r), 32'(fd_cnt - fd0), 32'd1);
            chk($sformatf("tbl%0d_err", r), 32'(fe_cnt - fe0), 32'(tbl[r].exp_err));
            chk($sformatf("tbl%0d_frame_cnt", r), 32'(frame_cnt), 32'(exp_frames));
            chk($sformatf("tbl%0d_idle", r), 32'(busy), 32'd0);
        end

        // Random frames against the reference model.
        for (int k = 0; k < 12; k++) begin
            fr_nl = $urandom_range(1, 3);
            fill_frame(fr_nl, $urandom_range(0, 11), 0, 1'b0);
            for (int l = 1; l < 4; l++) fr_len[l] = $urandom_range(0, 11);
            fd0 = fd_cnt; fe0 = fe_cnt;
            pulse_start(1'b0);
            model_frame(err);
            drive_frame(1'b0);
            exp_frames++;
            check_words($sformatf("rnd%0d", k));
            chk($sformatf("rnd%0d_done", k), 32'(fd_cnt - fd0), 32'd1);
            chk($sformatf("rnd%0d_err", k), 32'(fe_cnt - fe0), 32'(err));
            chk($sformatf("rnd%0d_frame_cnt", k), 32'(frame_cnt), 32'(exp_frames));
        end

        // Continuous capture, stop during frame 2; frame 3 must not appear.
        fill_frame(2, 8, 8, 1'b0);
        fd0 = fd_cnt; fe0 = fe_cnt;
        pulse_start(1'b1);
        model_frame(err);
        model_frame(err);
        drive_frame(1'b0);
        chk("cont_rearmed", 32'(busy), 32'd1);
        drive_frame(1'b1);
        chk("cont_idle", 32'(busy), 32'd0);
        drive_frame(1'b0);
        exp_frames += 2;
        check_words("cont");
        chk("cont_done", 32'(fd_cnt - fd0), 32'd2);
        chk("cont_err", 32'(fe_cnt - fe0), 32'd0);
        chk("cont_frame_cnt", 32'(frame_cnt), 32'(exp_frames));

        // Overflow with the consumer stalled: first four words survive.
        fill_frame(2, 8, 8, 1'b0);
        m_if.m_ready = 1'b0;
        fd0 = fd_cnt; fe0 = fe_cnt;
        pulse_start(1'b0);
        model_frame(err);
        while (exp_q.size() > 4) void'(exp_q.pop_back());
        drive_frame(1'b0);
        exp_frames++;
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_done", 32'(fd_cnt - fd0), 32'd1);
        chk("ovf_err", 32'(fe_cnt - fe0), 32'd1);
        chk("ovf_valid", 32'(m_if.m_valid), 32'd1);
        chk("ovf_head", 32'(m_if.m_data), 32'(exp_q[0].pixel));
        wait_clk(5);
        chk("ovf_head_held", 32'({m_if.m_sof, m_if.m_data}), 32'({exp_q[0].sof, exp_q[0].pixel}));
        m_if.m_ready = 1'b1;
        wait_clk(8);
        check_words("ovf");
        chk("ovf_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
        pulse_start(1'b0);
        chk("ovf_cleared_by_start", 32'(overflow), 32'd0);
        pulse_stop();
        chk("stop_in_wait_vs", 32'(busy), 32'd0);

        // Reset mid-line with three words buffered.
        fill_frame(2, 8, 8, 1'b0);
        m_if.m_ready = 1'b0;
        pulse_start(1'b0);
        vsync = 1'b0;
        wait_clk(8);
        hsync = 1'b1;
        wait_clk(2);
        for (int i = 0; i < 6; i++) beat(fr_byte[0][i]);
        wait_clk(4);
        chk("prerst_valid", 32'(m_if.m_valid), 32'd1);
        rst_n = 1'b0;
        wait_clk(1);
        rst_n = 1'b1;
        exp_frames = 0;
        chk("midrst_valid", 32'(m_if.m_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
        m_if.m_ready = 1'b1;
        fd0 = fd_cnt;
        beat(fr_byte[0][6]);
        beat(fr_byte[0][7]);
        hsync = 1'b0;
        wait_clk(6);
        hsync = 1'b1;
        wait_clk(2);
        for (int i = 0; i < 8; i++) beat(fr_byte[1][i]);
        hsync = 1'b0;
        wait_clk(6);
        vsync = 1'b1;
        wait_clk(12);
        chk("postrst_no_words", 32'(got_q.size() - got_rd), 32'd0);
        chk("postrst_no_done", 32'(fd_cnt - fd0), 32'd0);
        pulse_start(1'b0);
        model_frame(err);
        drive_frame(1'b0);
        exp_frames++;
        check_words("postrst");
        chk("postrst_frame_cnt", 32'(frame_cnt), 32'(exp_frames));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
